// File: rtl/object_bus_arbiter_if.sv
// Object-bus handshake bundle between the object cells, the arbiter and the consumer.
// The master modport is the arbiter's view; slave is the cells/consumer view.
interface object_bus_arbiter_if #(
    parameter int N_CELLS = 4,
    parameter int ID_W    = 4
);
    logic [N_CELLS-1:0] req;
    logic               ack;
    logic               bus_bit;
    logic               busy;
    logic [N_CELLS-1:0] grant;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               collision;

    modport master (
        input  req, ack,
        output bus_bit, busy, grant, grant_valid, grant_id, collision
    );

    modport slave (
        output req, ack,
        input  bus_bit, busy, grant, grant_valid, grant_id, collision
    );
endinterface

// File: rtl/object_bus_arbiter.sv
// Bit-serial wired-AND arbiter (MSB first, 0 dominant): lowest requesting ID wins, held until ack.
// Optional OBJECT_BUS_COLLISION_EN: duplicate-ID survivors pulse collision instead of granting.
module object_bus_arbiter #(
    parameter int                        N_CELLS = 4,
    parameter int                        ID_W    = 4,
    parameter logic [N_CELLS*ID_W-1:0]   IDS     = 16'h3D95
) (
    input logic                 clk,
    input logic                 rst,
    object_bus_arbiter_if.master bus
);
    localparam int BW = (ID_W > 1) ? $clog2(ID_W) : 1;
    localparam logic [BW-1:0] BIDX_TOP = BW'(ID_W - 1);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    state_t             state;
    logic [N_CELLS-1:0] cont;
    logic [BW-1:0]      bidx;

    logic [N_CELLS-1:0] cur_bits;
    logic               bus_bit_arb;
    logic [N_CELLS-1:0] cont_next;
    logic [N_CELLS-1:0] win;
    logic [ID_W-1:0]    win_id;
    logic               found;

    // Each cell's ID bit at the current position; non-contenders read as pulled up.
    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            cur_bits[i] = IDS[i*ID_W + int'(bidx)];
        end
    end

    assign bus_bit_arb = &(~cont | cur_bits);
    assign cont_next   = cont & ~(cur_bits & {N_CELLS{~bus_bit_arb}});
    assign bus.bus_bit = (state == ARB) ? bus_bit_arb : 1'b1;
    assign bus.busy    = (state != IDLE);

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (cont_next[i] && !found) begin
                win[i] = 1'b1;
                win_id = IDS[i*ID_W +: ID_W];
                found  = 1'b1;
            end
        end
    end

`ifdef OBJECT_BUS_COLLISION_EN
    logic multi;
    assign multi = |(cont_next & (cont_next - {{(N_CELLS-1){1'b0}}, 1'b1}));
`else
    assign bus.collision = 1'b0;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cont            <= '0;
            bidx            <= BIDX_TOP;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_id    <= '0;
`ifdef OBJECT_BUS_COLLISION_EN
            bus.collision   <= 1'b0;
`endif
        end else begin
`ifdef OBJECT_BUS_COLLISION_EN
            bus.collision <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        cont  <= bus.req;
                        bidx  <= BIDX_TOP;
                        state <= ARB;
                    end
                end
                ARB: begin
                    cont <= cont_next;
                    if (bidx == '0) begin
`ifdef OBJECT_BUS_COLLISION_EN
                        if (multi) begin
                            bus.collision <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            bus.grant       <= win;
                            bus.grant_valid <= 1'b1;
                            bus.grant_id    <= win_id;
                            state           <= GRANT;
                        end
`else
                        bus.grant       <= win;
                        bus.grant_valid <= 1'b1;
                        bus.grant_id    <= win_id;
                        state           <= GRANT;
`endif
                    end else begin
                        bidx <= bidx - 1'b1;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        bus.grant       <= '0;
                        bus.grant_valid <= 1'b0;
                        bus.grant_id    <= '0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_object_bus_arbiter.sv
// Directed bench: default-ID arbiter (5,9,D,3) and a second instance with IDs 5,D,5,3.
// Expected values are hand-derived from the ID bit patterns.
module tb_object_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    object_bus_arbiter_if #(.N_CELLS(4), .ID_W(4)) i0 ();
    object_bus_arbiter_if #(.N_CELLS(4), .ID_W(4)) i1 ();

    object_bus_arbiter #(.N_CELLS(4), .ID_W(4), .IDS(16'h3D95)) dut0 (
        .clk(clk), .rst(rst), .bus(i0.master)
    );
    object_bus_arbiter #(.N_CELLS(4), .ID_W(4), .IDS(16'h35D5)) dut1 (
        .clk(clk), .rst(rst), .bus(i1.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp0(input string tag, input logic busy, input logic bb,
                        input logic [3:0] g, input logic gv, input logic [3:0] id);
        check({tag, ".busy"}, 32'(i0.busy), 32'(busy));
        check({tag, ".bus_bit"}, 32'(i0.bus_bit), 32'(bb));
        check({tag, ".grant"}, 32'(i0.grant), 32'(g));
        check({tag, ".grant_valid"}, 32'(i0.grant_valid), 32'(gv));
        check({tag, ".grant_id"}, 32'(i0.grant_id), 32'(id));
    endtask

    task automatic exp1(input string tag, input logic busy, input logic bb,
                        input logic [3:0] g, input logic gv, input logic [3:0] id);
        check({tag, ".busy"}, 32'(i1.busy), 32'(busy));
        check({tag, ".bus_bit"}, 32'(i1.bus_bit), 32'(bb));
        check({tag, ".grant"}, 32'(i1.grant), 32'(g));
        check({tag, ".grant_valid"}, 32'(i1.grant_valid), 32'(gv));
        check({tag, ".grant_id"}, 32'(i1.grant_id), 32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        i0.req = '0;
        i0.ack = 1'b0;
        i1.req = '0;
        i1.ack = 1'b0;
        #12;
        exp0("reset", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);
        check("reset.collision", 32'(i0.collision), 32'd0);
        rst = 1'b0;
        tick();

        // Single requester, cell0 ID 5 = 0101.
        i0.req = 4'b0001;
        tick();
        exp0("single.b3", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        i0.req = 4'b0000;
        tick(); exp0("single.b2", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp0("single.b1", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        tick(); exp0("single.b0", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp0("single.grant", 1'b1, 1'b1, 4'b0001, 1'b1, 4'h5);
        tick(); tick();
        exp0("single.hold", 1'b1, 1'b1, 4'b0001, 1'b1, 4'h5);
        i0.ack = 1'b1;
        tick(); exp0("single.ack", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);
        i0.ack = 1'b0;
        tick(); exp0("single.idle", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);

        // dut1: cell0=5 vs cell1=D; cell1 withdraws at bit 3.
        i1.req = 4'b0011;
        tick(); exp1("pair.b3", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        tick(); exp1("pair.b2", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp1("pair.b1", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        tick(); exp1("pair.b0", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp1("pair.grant", 1'b1, 1'b1, 4'b0001, 1'b1, 4'h5);
        i1.ack = 1'b1;
        i1.req = 4'b0010;
        tick(); exp1("pair.ack", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);
        i1.ack = 1'b0;
        tick(); exp1("next.b3", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp1("next.b2", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp1("next.b1", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        tick(); exp1("next.b0", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        i1.req = 4'b0000;
        tick(); exp1("next.grant", 1'b1, 1'b1, 4'b0010, 1'b1, 4'hD);
        i1.ack = 1'b1;
        tick();
        i1.ack = 1'b0;
        exp1("next.ack", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);

        // All four request: IDs 5,9,D,3 -> cell3 wins.
        i0.req = 4'b1111;
        tick(); exp0("all.b3", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        i0.req = 4'b0000;
        tick(); exp0("all.b2", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        tick(); exp0("all.b1", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp0("all.b0", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick(); exp0("all.grant", 1'b1, 1'b1, 4'b1000, 1'b1, 4'h3);
        i0.ack = 1'b1;
        tick();
        i0.ack = 1'b0;

        // Contender set frozen: req drops cell0 mid-round, cell0 still wins.
        i0.req = 4'b0011;
        tick();
        i0.req = 4'b0010;
        tick(); tick(); tick();
        i0.req = 4'b0000;
        tick(); exp0("frozen.grant", 1'b1, 1'b1, 4'b0001, 1'b1, 4'h5);
        i0.ack = 1'b1;
        tick();
        i0.ack = 1'b0;

        // Asynchronous reset during bit 2, then a fresh round.
        i0.req = 4'b0011;
        tick();
        tick();
        exp0("prerst.b2", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        #2;
        rst = 1'b1;
        #1;
        exp0("midrst", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick();
        exp0("rsthold", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);
        rst = 1'b0;
        tick(); exp0("rerun.b3", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        i0.req = 4'b0000;
        tick(); tick(); tick();
        tick(); exp0("rerun.grant", 1'b1, 1'b1, 4'b0001, 1'b1, 4'h5);
        i0.ack = 1'b1;
        tick();
        i0.ack = 1'b0;

        // dut1: cell0 and cell2 both ID 5.
        i1.req = 4'b0101;
        tick(); exp1("dup.b3", 1'b1, 1'b0, 4'b0000, 1'b0, 4'h0);
        i1.req = 4'b0000;
        tick(); tick(); tick();
        exp1("dup.b0", 1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
        tick();
`ifdef OBJECT_BUS_COLLISION_EN
        exp1("dup.end", 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0);
        check("dup.collision", 32'(i1.collision), 32'd1);
        tick();
        check("dup.collision_off", 32'(i1.collision), 32'd0);
        check("dup.idle", 32'(i1.busy), 32'd0);
`else
        exp1("dup.grant", 1'b1, 1'b1, 4'b0001, 1'b1, 4'h5);
        check("dup.collision", 32'(i1.collision), 32'd0);
        i1.ack = 1'b1;
        tick();
        i1.ack = 1'b0;
        check("dup.idle", 32'(i1.busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
